// File: rtl/memory_stage.sv
// memory_stage: pipeline memory stage with a single outstanding data-memory access,
// wait-state stalling, timeout abort and sticky timeout/misalignment error flags.
package memory_stage_pkg;
    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic        mem_write;
        logic        reg_write;
        logic [4:0]  rd;
        logic        mem_read;
    } ex_to_mem_s;

    typedef struct packed {
        logic [31:0] result;
        logic        reg_write;
        logic [4:0]  rd;
    } mem_to_wb_s;
endpackage

module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  ex_to_mem_s  ex_to_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output mem_to_wb_s  mem_to_wb,
    output logic [31:0] bp_mem,
    output logic        stall,
    output logic        err_timeout,
    output logic        err_misalign
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic        we_q, rw_q;
    logic [4:0]  rd_q;
    mem_to_wb_s  wb_q, wb_d;
    logic        err_to_q, err_to_d, err_mis_q, err_mis_d;
    logic        access, mis, waiting, abort, complete, c_rw;
    logic [4:0]  c_rd;

    always_comb begin
        access     = ex_to_mem.mem_read | ex_to_mem.mem_write;
        mis        = access & (|ex_to_mem.alu_result[1:0]);
        waiting    = state_q == S_WAIT;
        abort      = waiting & !dmem_ready & (cnt_q == CW'(TIMEOUT - 1));
        // rst gates the request combinationally so it drops the instant reset rises
        dmem_req   = !rst & (waiting | (access & !mis));
        dmem_we    = waiting ? we_q : ex_to_mem.mem_write;
        dmem_addr  = waiting ? addr_q : ex_to_mem.alu_result;
        dmem_wdata = waiting ? wdata_q : ex_to_mem.write_data;
        c_rw       = waiting ? rw_q : ex_to_mem.reg_write;
        c_rd       = waiting ? rd_q : ex_to_mem.rd;
        stall      = dmem_req & !dmem_ready & !abort;
        complete   = dmem_req & dmem_ready;
        bp_mem     = ex_to_mem.alu_result;
        state_d    = stall ? S_WAIT : S_IDLE;
        cnt_d      = (waiting & stall) ? cnt_q + 1'b1 : '0;
        wb_d       = '0;
        if (!waiting & !access)
            wb_d = '{result: ex_to_mem.alu_result, reg_write: ex_to_mem.reg_write, rd: ex_to_mem.rd};
        else if (complete)
            wb_d = '{result: dmem_we ? dmem_addr : dmem_rdata, reg_write: c_rw & !dmem_we, rd: c_rd};
        err_to_d   = err_to_q | abort;
        err_mis_d  = err_mis_q | (!waiting & mis);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rw_q      <= 1'b0;
            rd_q      <= '0;
            wb_q      <= '0;
            err_to_q  <= 1'b0;
            err_mis_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wb_q      <= wb_d;
            err_to_q  <= err_to_d;
            err_mis_q <= err_mis_d;
            if (!waiting & stall) begin
                addr_q  <= ex_to_mem.alu_result;
                wdata_q <= ex_to_mem.write_data;
                we_q    <= ex_to_mem.mem_write;
                rw_q    <= ex_to_mem.reg_write;
                rd_q    <= ex_to_mem.rd;
            end
        end
    end

    assign mem_to_wb    = wb_q;
    assign err_timeout  = err_to_q;
    assign err_misalign = err_mis_q;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: random and directed instruction stream against an instruction-level
// model; expectations are queued by the driver and checked by an independent monitor.
module tb_memory_stage;
    import memory_stage_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    ex_to_mem_s  ex;
    logic        req, we, ready, stall, eto, emis;
    logic [31:0] addr, wdata, rdata, bp;
    mem_to_wb_s  wb;

    memory_stage #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .ex_to_mem(ex),
        .dmem_req(req), .dmem_we(we), .dmem_addr(addr), .dmem_wdata(wdata),
        .dmem_ready(ready), .dmem_rdata(rdata),
        .mem_to_wb(wb), .bp_mem(bp), .stall(stall),
        .err_timeout(eto), .err_misalign(emis)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req, stall, we;
        logic [31:0] addr, wdata, bp;
    } comb_t;
    typedef struct {
        logic [31:0] result;
        logic        rw;
        logic [4:0]  rd;
        logic        eto, emis;
    } wbx_t;

    comb_t cq[$];
    wbx_t  wq[$];
    comb_t c;
    wbx_t  prev;
    bit    have_prev = 0, mon_en = 0, m_eto = 0, m_emis = 0;
    int    checks = 0, errors = 0;

    always @(negedge clk) if (mon_en) begin
        if (cq.size() != 0) begin
            c = cq.pop_front();
            checks++;
            if (req !== c.req || stall !== c.stall || bp !== c.bp ||
                (c.req && (addr !== c.addr || we !== c.we || wdata !== c.wdata))) begin
                errors++;
                $display("FAIL comb t=%0t: got req=%b stall=%b addr=%h we=%b wdata=%h bp=%h, expected req=%b stall=%b addr=%h we=%b wdata=%h bp=%h",
                         $time, req, stall, addr, we, wdata, bp, c.req, c.stall, c.addr, c.we, c.wdata, c.bp);
            end
        end
        if (have_prev) begin
            checks++;
            if (wb.result !== prev.result || wb.reg_write !== prev.rw || wb.rd !== prev.rd ||
                eto !== prev.eto || emis !== prev.emis) begin
                errors++;
                $display("FAIL writeback t=%0t: got result=%h rw=%b rd=%0d eto=%b emis=%b, expected result=%h rw=%b rd=%0d eto=%b emis=%b",
                         $time, wb.result, wb.reg_write, wb.rd, eto, emis, prev.result, prev.rw, prev.rd, prev.eto, prev.emis);
            end
        end
        have_prev = wq.size() != 0;
        if (have_prev) prev = wq.pop_front();
    end

    function automatic ex_to_mem_s mk(logic [31:0] a, logic [31:0] wd, logic mw, logic rw, logic [4:0] rd, logic mr);
        ex_to_mem_s e;
        e.alu_result = a; e.write_data = wd; e.mem_write = mw;
        e.reg_write = rw; e.rd = rd; e.mem_read = mr;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One instruction held upstream until it leaves the stage; k = cycles of ready=0 before ready.
    task automatic run_instr(input ex_to_mem_s e, input int k);
        bit    acc, mis, mem;
        int    n;
        comb_t ce;
        wbx_t  we_x;
        acc = e.mem_read || e.mem_write;
        mis = acc && e.alu_result[1:0] != 2'b00;
        mem = acc && !mis;
        n = !mem ? 1 : (k <= T ? k + 1 : T + 1);
        for (int j = 0; j < n; j++) begin
            @(posedge clk); #1;
            ex = e;
            rdata = $urandom;
            ready = mem ? (j == k) : 1'($urandom);
            ce.req = mem; ce.stall = mem && j < n - 1; ce.we = e.mem_write;
            ce.addr = e.alu_result; ce.wdata = e.write_data; ce.bp = e.alu_result;
            cq.push_back(ce);
            we_x.result = 0; we_x.rw = 0; we_x.rd = 0;
            if (!acc) begin
                we_x.result = e.alu_result; we_x.rw = e.reg_write; we_x.rd = e.rd;
            end else if (mis) begin
                m_emis = 1;
            end else if (j == n - 1) begin
                if (k <= T) begin
                    we_x.result = e.mem_write ? e.alu_result : rdata;
                    we_x.rw = e.reg_write && !e.mem_write;
                    we_x.rd = e.rd;
                end else m_eto = 1;
            end
            we_x.eto = m_eto; we_x.emis = m_emis;
            wq.push_back(we_x);
        end
    endtask

    task automatic drain();
        @(posedge clk); #1;
        ex = '0; ready = 0;
        @(negedge clk); #1;
        mon_en = 0;
    endtask

    initial begin
        rst = 0; ex = '0; ready = 0; rdata = 0;
        #2 rst = 1;
        ex = mk(32'h100, 0, 0, 1, 7, 1);
        #1;
        chk("reset_req", {63'd0, req}, 0);
        chk("reset_stall", {63'd0, stall}, 0);
        chk("reset_wb", {25'd0, wb}, 0);
        chk("reset_flags", {62'd0, eto, emis}, 0);
        @(posedge clk); #1;
        rst = 0; ex = '0;
        mon_en = 1;

        run_instr(mk(32'h10, 0, 0, 1, 5, 0), 0);
        run_instr(mk(32'h100, 0, 0, 1, 7, 1), 0);
        run_instr(mk(32'h200, 32'h55, 1, 1, 4, 0), 3);
        run_instr(mk(32'h300, 0, 0, 1, 8, 1), T + 5);
        run_instr(mk(32'h102, 0, 0, 1, 9, 1), 0);
        run_instr(mk(32'h104, 32'h77, 1, 0, 2, 1), T);
        drain();

        @(posedge clk); #1;
        ex = mk(32'h300, 0, 0, 1, 9, 1); ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wait_req", {63'd0, req}, 1);
        rst = 1;
        #1;
        chk("rst_wait_req", {63'd0, req}, 0);
        chk("rst_wait_stall", {63'd0, stall}, 0);
        chk("rst_wait_wb", {25'd0, wb}, 0);
        chk("rst_wait_flags", {62'd0, eto, emis}, 0);
        @(posedge clk); #1;
        chk("rst_hold_req", {63'd0, req}, 0);
        rst = 0; ex = '0;
        @(negedge clk);
        chk("post_rst_wb", {25'd0, wb}, 0);
        m_eto = 0; m_emis = 0; have_prev = 0;
        cq.delete(); wq.delete();
        mon_en = 1;
        run_instr(mk(32'h104, 0, 0, 1, 3, 1), 1);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            int sel;
            a = $urandom;
            if ($urandom_range(0, 9) < 8) a[1:0] = 2'b00;
            sel = $urandom_range(0, 3);
            run_instr(mk(a, $urandom, sel[1], 1'($urandom), 5'($urandom), sel[0]), $urandom_range(0, T + 2));
        end
        drain();
        chk("queues_drained", 64'(cq.size() + wq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
